mips_multicycle_ctrl: RTL and testbench

- Main control unit for the multicycle MIPS datapath.
- Sequences each instruction through FETCH/DECODE/execute/memory/writeback states and drives every datapath select and write-enable.
- Consumes the opcode field (instruction[31:26]) from the instruction register.
- Stalls on a memory-ready handshake and reports instruction retirement and illegal opcodes.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 67 ++++++
 rtl/mips_multicycle_ctrl_if.sv | 28 ++
 rtl/mips_multicycle_ctrl_decode.sv | 75 +++++++
 rtl/mips_multicycle_ctrl.sv | 78 +++++++
 tb/tb_mips_multicycle_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
// Holds the opcode constants, the 4-bit state encodings, the ALUOp codes,
// the control-word struct the state decoder produces, and the opcode
// dispatch helpers used in DECODE.
package mips_multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_word_t;

    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // Unknown opcodes fall back to FETCH; the caller flags them separately.
    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEM_ADDR;
            OP_RTYPE:     return S_EXECUTE;
            OP_BEQ:       return S_BRANCH;
            OP_J:         return S_JUMP;
            OP_ADDI:      return S_ADDI_EX;
            default:      return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle.
// master: the control unit (drives selects/enables, state, status, counter;
//         reads opcode and mem_ready).
// slave:  the datapath/memory side (the mirror image).
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic             MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [3:0]       state;
    logic             instr_done, illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, ALUSrcB, ALUOp, PCSource,
               state, instr_done, illegal_op, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, ALUSrcB, ALUOp, PCSource,
               state, instr_done, illegal_op, instr_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl_decode.sv
// mc_ctrl_decode: purely combinational state -> control word decode.
// Ports: state (current FSM state), mem_ready (effective memory ready,
// already forced high when the controller does not wait), cw (control word).
// Only the FETCH write-enables and the MEM_WRITE retirement pulse depend on
// mem_ready; everything else is Moore.
module mc_ctrl_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_word_t cw
);
    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = 2'b01;
                cw.alu_op    = ALUOP_ADD;
                cw.ir_write  = mem_ready;
                cw.pc_write  = mem_ready;
            end
            S_DECODE: begin
                cw.alu_src_b = 2'b11;
                cw.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = 2'b10;
                cw.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                cw.mem_read = 1'b1;
                cw.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                // Write strobe held through the stall; retire on completion.
                cw.mem_write  = 1'b1;
                cw.i_or_d     = 1'b1;
                cw.instr_done = mem_ready;
            end
            S_EXECUTE: begin
                cw.alu_src_a = 1'b1;
                cw.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                cw.reg_write  = 1'b1;
                cw.reg_dst    = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_op        = ALUOP_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_source     = 2'b01;
                cw.instr_done    = 1'b1;
            end
            S_JUMP: begin
                cw.pc_write   = 1'b1;
                cw.pc_source  = 2'b10;
                cw.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                cw.reg_write  = 1'b1;
                cw.instr_done = 1'b1;
            end
            default: cw = '0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM for the multicycle MIPS datapath.
// Ports: clock, reset (sync, active-high), bus (master side of
// mips_multicycle_ctrl_if: opcode/mem_ready in; datapath controls, state,
// instr_done, illegal_op, instr_count out).
// Holds the state register, next-state logic and retired-instruction counter;
// the control word itself comes from mc_ctrl_decode.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter bit WAIT_FOR_MEM = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);
    state_t           state_q, state_d;
    ctrl_word_t       cw, cw_out;
    logic             rdy, illegal;
    logic [CNT_W-1:0] cnt_q;

    assign rdy = WAIT_FOR_MEM ? bus.mem_ready : 1'b1;

    mc_ctrl_decode u_dec (
        .state     (state_q),
        .mem_ready (rdy),
        .cw        (cw)
    );

    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:     state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_d = dispatch(bus.opcode);
                illegal = !op_known(bus.opcode);
            end
            S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = rdy ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = rdy ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cw.instr_done) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Everything the datapath sees is quiet while reset is held.
    assign cw_out = reset ? '0 : cw;

    assign bus.PCWrite     = cw_out.pc_write;
    assign bus.PCWriteCond = cw_out.pc_write_cond;
    assign bus.IorD        = cw_out.i_or_d;
    assign bus.MemRead     = cw_out.mem_read;
    assign bus.MemWrite    = cw_out.mem_write;
    assign bus.MemtoReg    = cw_out.mem_to_reg;
    assign bus.IRWrite     = cw_out.ir_write;
    assign bus.ALUSrcA     = cw_out.alu_src_a;
    assign bus.RegWrite    = cw_out.reg_write;
    assign bus.RegDst      = cw_out.reg_dst;
    assign bus.ALUSrcB     = cw_out.alu_src_b;
    assign bus.ALUOp       = cw_out.alu_op;
    assign bus.PCSource    = cw_out.pc_source;
    assign bus.instr_done  = cw_out.instr_done;
    assign bus.illegal_op  = illegal && !reset;
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl (CNT_W=4 so the
// counter wrap is reachable), plus a hand-written wrap sequence.
module tb_mips_multicycle_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    mips_multicycle_ctrl_if #(.CNT_W(4)) bus ();

    mips_multicycle_ctrl #(.WAIT_FOR_MEM(1'b1), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
    //  RegWrite,RegDst,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
    logic [15:0] act_ctrl;
    assign act_ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                       bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.ALUSrcA,
                       bus.RegWrite, bus.RegDst, bus.ALUSrcB, bus.ALUOp, bus.PCSource};

    localparam logic [15:0] C_NONE  = 16'h0000;
    localparam logic [15:0] C_FGO   = 16'h9210;
    localparam logic [15:0] C_FSTL  = 16'h1010;
    localparam logic [15:0] C_DEC   = 16'h0030;
    localparam logic [15:0] C_MADDR = 16'h0120;
    localparam logic [15:0] C_MRD   = 16'h3000;
    localparam logic [15:0] C_MWB   = 16'h0480;
    localparam logic [15:0] C_MWR   = 16'h2800;
    localparam logic [15:0] C_EXE   = 16'h0108;
    localparam logic [15:0] C_RWB   = 16'h00C0;
    localparam logic [15:0] C_BR    = 16'h4105;
    localparam logic [15:0] C_JMP   = 16'h8002;
    localparam logic [15:0] C_AEX   = 16'h0120;
    localparam logic [15:0] C_AWB   = 16'h0080;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic        chk;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        done;
        logic        ill;
        logic [3:0]  cnt;
    } vec_t;

    localparam int NV = 38;
    vec_t tv [NV];

    function automatic vec_t mk(logic rst, logic [5:0] op, logic rdy, logic chk,
                                logic [3:0] st, logic [15:0] ctrl, logic done,
                                logic ill, logic [3:0] cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.chk = chk; v.st = st;
        v.ctrl = ctrl; v.done = done; v.ill = ill; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string nm, input int row, input logic [15:0] act,
                         input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // reset (2 cycles, all outputs quiet)
        tv[0]  = mk(1, 6'h00, 1, 0, 4'd0, C_NONE,  0, 0, 4'd0);
        tv[1]  = mk(1, 6'h00, 1, 1, 4'd0, C_NONE,  0, 0, 4'd0);
        // lw, no stalls: 0,1,2,3,4
        tv[2]  = mk(0, 6'h23, 1, 1, 4'd0, C_FGO,   0, 0, 4'd0);
        tv[3]  = mk(0, 6'h23, 1, 1, 4'd1, C_DEC,   0, 0, 4'd0);
        tv[4]  = mk(0, 6'h23, 1, 1, 4'd2, C_MADDR, 0, 0, 4'd0);
        tv[5]  = mk(0, 6'h23, 1, 1, 4'd3, C_MRD,   0, 0, 4'd0);
        tv[6]  = mk(0, 6'h23, 1, 1, 4'd4, C_MWB,   1, 0, 4'd0);
        // sw with three stall cycles in MEM_WRITE
        tv[7]  = mk(0, 6'h2B, 1, 1, 4'd0, C_FGO,   0, 0, 4'd1);
        tv[8]  = mk(0, 6'h2B, 1, 1, 4'd1, C_DEC,   0, 0, 4'd1);
        tv[9]  = mk(0, 6'h2B, 1, 1, 4'd2, C_MADDR, 0, 0, 4'd1);
        tv[10] = mk(0, 6'h2B, 0, 1, 4'd5, C_MWR,   0, 0, 4'd1);
        tv[11] = mk(0, 6'h2B, 0, 1, 4'd5, C_MWR,   0, 0, 4'd1);
        tv[12] = mk(0, 6'h2B, 0, 1, 4'd5, C_MWR,   0, 0, 4'd1);
        tv[13] = mk(0, 6'h2B, 1, 1, 4'd5, C_MWR,   1, 0, 4'd1);
        // R-type
        tv[14] = mk(0, 6'h00, 1, 1, 4'd0, C_FGO,   0, 0, 4'd2);
        tv[15] = mk(0, 6'h00, 1, 1, 4'd1, C_DEC,   0, 0, 4'd2);
        tv[16] = mk(0, 6'h00, 1, 1, 4'd6, C_EXE,   0, 0, 4'd2);
        tv[17] = mk(0, 6'h00, 1, 1, 4'd7, C_RWB,   1, 0, 4'd2);
        // beq
        tv[18] = mk(0, 6'h04, 1, 1, 4'd0, C_FGO,   0, 0, 4'd3);
        tv[19] = mk(0, 6'h04, 1, 1, 4'd1, C_DEC,   0, 0, 4'd3);
        tv[20] = mk(0, 6'h04, 1, 1, 4'd8, C_BR,    1, 0, 4'd3);
        // j
        tv[21] = mk(0, 6'h02, 1, 1, 4'd0, C_FGO,   0, 0, 4'd4);
        tv[22] = mk(0, 6'h02, 1, 1, 4'd1, C_DEC,   0, 0, 4'd4);
        tv[23] = mk(0, 6'h02, 1, 1, 4'd9, C_JMP,   1, 0, 4'd4);
        // addi
        tv[24] = mk(0, 6'h08, 1, 1, 4'd0, C_FGO,   0, 0, 4'd5);
        tv[25] = mk(0, 6'h08, 1, 1, 4'd1, C_DEC,   0, 0, 4'd5);
        tv[26] = mk(0, 6'h08, 1, 1, 4'd10, C_AEX,  0, 0, 4'd5);
        tv[27] = mk(0, 6'h08, 1, 1, 4'd11, C_AWB,  1, 0, 4'd5);
        // illegal opcode: flagged in DECODE, back to FETCH, no retirement
        tv[28] = mk(0, 6'h3F, 1, 1, 4'd0, C_FGO,   0, 0, 4'd6);
        tv[29] = mk(0, 6'h3F, 1, 1, 4'd1, C_DEC,   0, 1, 4'd6);
        // FETCH stall, then lw with mem_ready ignored outside memory states
        tv[30] = mk(0, 6'h3F, 0, 1, 4'd0, C_FSTL,  0, 0, 4'd6);
        tv[31] = mk(0, 6'h23, 1, 1, 4'd0, C_FGO,   0, 0, 4'd6);
        tv[32] = mk(0, 6'h23, 0, 1, 4'd1, C_DEC,   0, 0, 4'd6);
        tv[33] = mk(0, 6'h23, 0, 1, 4'd2, C_MADDR, 0, 0, 4'd6);
        tv[34] = mk(0, 6'h23, 0, 1, 4'd3, C_MRD,   0, 0, 4'd6);
        tv[35] = mk(0, 6'h23, 0, 1, 4'd3, C_MRD,   0, 0, 4'd6);
        // reset while stalled in MEM_READ: abandoned, counter cleared
        tv[36] = mk(1, 6'h23, 0, 1, 4'd3, C_NONE,  0, 0, 4'd6);
        tv[37] = mk(0, 6'h00, 1, 1, 4'd0, C_FGO,   0, 0, 4'd0);

        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b1;

        for (int i = 0; i < NV; i++) begin
            reset         = tv[i].rst;
            bus.opcode    = tv[i].op;
            bus.mem_ready = tv[i].rdy;
            @(negedge clock);
            check("ctrl", i, act_ctrl, tv[i].ctrl);
            check("instr_done", i, {15'd0, bus.instr_done}, {15'd0, tv[i].done});
            check("illegal_op", i, {15'd0, bus.illegal_op}, {15'd0, tv[i].ill});
            if (tv[i].chk) begin
                check("state", i, {12'd0, bus.state}, {12'd0, tv[i].st});
                check("instr_count", i, {12'd0, bus.instr_count}, {12'd0, tv[i].cnt});
            end
            step();
        end

        // Counter wrap: 16 jumps on a 4-bit counter return it to 0.
        reset         = 1'b1;
        bus.opcode    = 6'h02;
        bus.mem_ready = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            check("wrap_fetch", 100 + k, {12'd0, bus.state}, 16'd0);
            step();
            @(negedge clock);
            check("wrap_decode", 100 + k, {12'd0, bus.state}, 16'd1);
            step();
            @(negedge clock);
            check("wrap_jump", 100 + k, act_ctrl, C_JMP);
            check("wrap_done", 100 + k, {15'd0, bus.instr_done}, 16'd1);
            check("wrap_count", 100 + k, {12'd0, bus.instr_count}, 16'(k));
            step();
        end
        @(negedge clock);
        check("wrap_final_state", 116, {12'd0, bus.state}, 16'd0);
        check("wrap_final_count", 116, {12'd0, bus.instr_count}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
